dpr_port_arbiter: RTL
=====================

// Module: dpr_port_arbiter
// PURPOSE
//  Shares one port of a dual_port_ram among NUM_REQ requesters with round-robin arbitration.
//  After reset it first clears the whole RAM, then accepts read/write requests via valid/ready.
//  Read data returns to the granted requester exactly one cycle after acceptance.
//  Sits between cache/refill logic and one RAM port (a or b); one instance per port.
// PARAMETERS
//  DATA_WIDTH  32  RAM word width
//  ADDR_WIDTH  9   RAM address width; depth = 2**ADDR_WIDTH
//  NUM_REQ     3   number of requesters (>=2)
//  INIT_EN     1   1: zero-fill RAM after reset; 0: go straight to RUN
// PORTS
//  clk          in   1                   clock, all state on posedge
//  rst          in   1                   reset, asynchronous, active-high
//  req_valid    in   NUM_REQ             per-requester request valid
//  req_ready    out  NUM_REQ             per-requester accept (one-hot or zero)
//  req_we       in   NUM_REQ             1 = write, 0 = read
//  req_addr     in   NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata    in   NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rsp_valid    out  NUM_REQ             one-cycle pulse: read data for requester i
//  rsp_rdata    out  DATA_WIDTH          read data, valid with any rsp_valid bit
//  init_done    out  1                   1 once clear sweep complete (RUN state)
//  ram_we       out  1                   to RAM we_x
//  ram_addr     out  ADDR_WIDTH          to RAM addr_x
//  ram_din      out  DATA_WIDTH          to RAM din_x
//  ram_dout     in   DATA_WIDTH          from RAM dout_x (registered, 1-cycle read)
// BEHAVIOUR
//  Reset: state=INIT (RUN if INIT_EN=0), clr_cnt=0, rr_ptr=0, rsp_valid=0, init_done=0 (1 if INIT_EN=0).
//  While rst high: ram_we=0, req_ready=0.
//  INIT: each cycle ram_we=1, ram_addr=clr_cnt, ram_din=0; clr_cnt++; req_ready=0.
//   At clr_cnt=2**ADDR_WIDTH-1: write it, next cycle state=RUN, init_done=1 (sweep = 2**ADDR_WIDTH cycles).
//  RUN: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready = one-hot(g) when any valid, else 0; combinational from req_valid (same cycle).
//   ram_we=req_we[g], ram_addr/ram_din = requester g fields; no grant -> ram_we=0, addr/din hold don't-care.
//   On grant: rr_ptr <= (g+1) mod NUM_REQ; no grant -> rr_ptr unchanged.
//  Read accepted cycle t -> rsp_valid[g]=1 in cycle t+1, rsp_rdata=ram_dout; writes give no response.
//  Back-to-back reads sustain 1 accept/cycle; responses in acceptance order, never dropped or stalled.
//  Same-address write at t then read at t+1 returns new data; read at same cycle as own write impossible.
//  Requester may drop req_valid without acceptance; no state retained for unaccepted requests.
//  rst mid-INIT restarts sweep at 0; rst mid-RUN drops in-flight rsp_valid (cleared asynchronously).
//  rr_ptr is $clog2(NUM_REQ) bits; wrap NUM_REQ-1 -> 0 explicitly (NUM_REQ need not be power of 2).
//  rsp_rdata equals ram_dout in all cycles; only meaningful with rsp_valid.
// TESTING
//  Reset, ADDR_WIDTH=4, INIT_EN=1 -> 16 cycles ram_we=1 addr 0..15 din 0, req_ready=0, then init_done=1.
//  After init, req0 reads addr 5 -> next cycle rsp_valid=3'b001, rsp_rdata=0.
//  All 3 valid reads held 6 cycles, rr_ptr=0 -> grants 0,1,2,0,1,2; responses follow one cycle later.
//  req1 writes 0xDEADBEEF @7 cycle t, req2 reads @7 cycle t+1 -> rsp_valid=3'b100, rdata=0xDEADBEEF at t+2.
//  Only req2 valid repeatedly -> granted every cycle, rr_ptr stays 0 after each (2+1 mod 3).
//  rst pulsed mid-sweep at clr_cnt=9 -> sweep restarts at 0, init_done low, no rsp_valid.

Source files
------------

// File: rtl/dpr_port_arbiter_if.sv
// dpr_port_arbiter_if: requester handshake and RAM-port signals of one arbitrated RAM port.
interface dpr_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int NUM_REQ    = 3
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          init_done;
   logic                          ram_we;
   logic [ADDR_WIDTH-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0]         ram_din;
   logic [DATA_WIDTH-1:0]         ram_dout;
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, ram_dout,
      output req_ready, rsp_valid, rsp_rdata, init_done, ram_we, ram_addr, ram_din
   );
   modport master (
      output req_valid, req_we, req_addr, req_wdata, ram_dout,
      input  req_ready, rsp_valid, rsp_rdata, init_done, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/dpr_port_arbiter.sv
// dpr_port_arbiter: round-robin sharing of one RAM port, with a zero-fill sweep after reset.
module dpr_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int NUM_REQ    = 3,
   parameter bit INIT_EN    = 1'b1
) (
   input logic clk,
   input logic rst,
   dpr_port_arbiter_if.slave bus
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   typedef enum logic {INIT, RUN} state_t;
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [PW-1:0]         rr_ptr, grant;
   logic [PW:0]           s;
   logic                  any, run, we_g;
   logic [NUM_REQ-1:0]    ready_oh, rsp_q;
   logic [ADDR_WIDTH-1:0] addr_g;
   logic [DATA_WIDTH-1:0] data_g;
   always_comb begin
      any      = 1'b0;
      grant    = '0;
      s        = '0;
      ready_oh = '0;
      we_g     = 1'b0;
      addr_g   = '0;
      data_g   = '0;
      // walk downward so the candidate nearest rr_ptr is the last one written
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         s = {1'b0, rr_ptr} + (PW+1)'(k);
         if (s >= (PW+1)'(NUM_REQ)) s = s - (PW+1)'(NUM_REQ);
         if (bus.req_valid[s[PW-1:0]]) begin
            any   = 1'b1;
            grant = s[PW-1:0];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == PW'(i)) begin
            we_g   = bus.req_we[i];
            addr_g = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_g = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (any) ready_oh[grant] = 1'b1;
      run           = state == RUN && !rst;
      state_nx      = state == INIT && clr_cnt == '1 ? RUN : state;
      bus.req_ready = run ? ready_oh : '0;
      bus.ram_we    = !rst && (state == INIT || (any && we_g));
      bus.ram_addr  = state == INIT ? clr_cnt : addr_g;
      bus.ram_din   = state == INIT ? '0 : data_g;
      bus.rsp_valid = rsp_q;
      bus.rsp_rdata = bus.ram_dout;
      bus.init_done = state == RUN;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= INIT_EN ? INIT : RUN;
         clr_cnt <= '0;
         rr_ptr  <= '0;
         rsp_q   <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= state == INIT ? clr_cnt + 1'b1 : clr_cnt;
         rr_ptr  <= run && any ? (grant == PW'(NUM_REQ - 1) ? '0 : grant + 1'b1) : rr_ptr;
         rsp_q   <= run && any && !we_g ? ready_oh : '0;
      end
   end
endmodule
